// File: rtl/mux_arb_pkg.sv
// Shared select encoding and counter width for the round-robin 2:1 mux arbiter.
package mux_arb_pkg;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_t;

    localparam int ARB_CNT_W = 16;

endpackage

// File: rtl/mux_2to1_d.sv
// Data-flow 2:1 mux: y follows a when sel=0, b when sel=1.
module mux_2to1_d #(
    parameter int width = 16
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             sel,
    output logic [width-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mux_2to1_rr_arb.sv
// Round-robin arbiter driving a shared 2:1 mux into a valid/ready output register.
// Optional accepted-word counters are built when MUX_RR_ARB_STATS_EN is defined.
module mux_2to1_rr_arb
    import mux_arb_pkg::*;
#(
    parameter int width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    input  logic [width-1:0]     a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [width-1:0]     b_data,
    output logic                 b_ready,
    output logic                 out_valid,
    output logic [width-1:0]     out_data,
    output logic                 out_sel,
    input  logic                 out_ready
`ifdef MUX_RR_ARB_STATS_EN
    ,
    output logic [ARB_CNT_W-1:0] cnt_a,
    output logic [ARB_CNT_W-1:0] cnt_b
`endif
);

    sel_t             last;
    sel_t             winner;
    sel_t             sel_q;
    logic             have_winner;
    logic             space;
    logic             load;
    logic [width-1:0] win_data;

    assign space = !out_valid || out_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        winner      = SEL_A;
        have_winner = a_valid || b_valid;
        if (a_valid && b_valid) begin
            winner = (last == SEL_A) ? SEL_B : SEL_A;
        end else if (b_valid) begin
            winner = SEL_B;
        end
    end

    assign load    = space && have_winner;
    // Ready is suppressed during reset so no word is reported accepted and then lost.
    assign a_ready = !rst && load && (winner == SEL_A);
    assign b_ready = !rst && load && (winner == SEL_B);

    mux_2to1_d #(
        .width (width)
    ) u_mux (
        .a   (a_data),
        .b   (b_data),
        .sel (winner),
        .y   (win_data)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            sel_q     <= SEL_A;
            last      <= SEL_B;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            sel_q     <= winner;
            last      <= winner;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_sel = sel_q;

`ifdef MUX_RR_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (a_ready && a_valid) cnt_a <= cnt_a + 1'b1;
            if (b_ready && b_valid) cnt_b <= cnt_b + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_2to1_rr_arb.sv
// Scoreboard bench for mux_2to1_rr_arb: directed stimulus pushes expected words,
// a monitor pops and compares on every output handshake.
module tb_mux_2to1_rr_arb;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         a_valid = 1'b0;
    logic [W-1:0] a_data = '0;
    logic         a_ready;
    logic         b_valid = 1'b0;
    logic [W-1:0] b_data = '0;
    logic         b_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_sel;
    logic         out_ready = 1'b0;
`ifdef MUX_RR_ARB_STATS_EN
    logic [15:0]  cnt_a;
    logic [15:0]  cnt_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [W:0] exp_q[$];

    always #5 clk = ~clk;

    mux_2to1_rr_arb #(.width(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
`ifdef MUX_RR_ARB_STATS_EN
        ,
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake on the output must match the oldest expected word.
    initial begin
        logic [W:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {15'd0, out_sel, out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[W-1:0]);
                    check("out_sel", out_sel, e[W]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst = 1'b1; a_valid = 1'b1; a_data = 16'hA000; b_valid = 1'b0; out_ready = 1'b1;
            exp_q.delete();
            #3;
            check("rst_a_ready", a_ready, 0);
            check("rst_b_ready", b_ready, 0);
        end
        @(posedge clk); #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sel", out_sel, 0);
`ifdef MUX_RR_ARB_STATS_EN
        check("rst_cnt_a", cnt_a, 0);
        check("rst_cnt_b", cnt_b, 0);
`endif
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    endtask

    // One cycle of stimulus with hand-computed ready expectations.
    task automatic step(input string name,
                        input logic av, input logic [W-1:0] ad,
                        input logic bv, input logic [W-1:0] bd,
                        input logic ordy, input logic ear, input logic ebr);
        @(posedge clk); #1;
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
        #3;
        check({name, "_a_ready"}, a_ready, ear);
        check({name, "_b_ready"}, b_ready, ebr);
        if (ear) exp_q.push_back({1'b0, ad});
        if (ebr) exp_q.push_back({1'b1, bd});
    endtask

    initial begin
        do_reset(2);

        // Tie alternation from reset: A first, then B, A, B, A, B.
        for (int i = 0; i < 6; i++)
            step("tie", 1, 16'hA000, 1, 16'hB000, 1, (i % 2) == 0, (i % 2) == 1);

        step("a_only", 1, 16'hA000, 0, 16'h0000, 1, 1, 0);
        step("b_only", 0, 16'h0000, 1, 16'hB000, 1, 0, 1);

        // Backpressure: C000 held while both requesters wait.
        step("fill", 1, 16'hC000, 0, 16'h0000, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step("stall", 1, 16'hA001, 1, 16'hB001, 0, 0, 0);
            check("stall_out_data", out_data, 16'hC000);
            check("stall_out_sel", out_sel, 0);
            check("stall_out_valid", out_valid, 1);
        end
        step("release", 1, 16'hA001, 1, 16'hB001, 1, 0, 1);
        step("idle", 0, 16'h0000, 0, 16'h0000, 1, 0, 0);

        // Reset while D000 sits in the output register.
        step("load_d", 1, 16'hD000, 0, 16'h0000, 1, 1, 0);
        step("hold_d", 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
        check("hold_d_data", out_data, 16'hD000);
        do_reset(1);
        step("post_rst_tie", 1, 16'hA000, 1, 16'hB000, 1, 1, 0);
        step("post_rst_tie2", 1, 16'hA000, 1, 16'hB000, 1, 0, 1);
        step("idle2", 0, 16'h0000, 0, 16'h0000, 1, 0, 0);

`ifdef MUX_RR_ARB_STATS_EN
        do_reset(1);
        step("st_a1", 1, 16'h0A01, 0, 16'h0000, 1, 1, 0);
        step("st_b1", 0, 16'h0000, 1, 16'h0B01, 1, 0, 1);
        step("st_a2", 1, 16'h0A02, 0, 16'h0000, 1, 1, 0);
        step("st_b2", 0, 16'h0000, 1, 16'h0B02, 1, 0, 1);
        step("st_a3", 1, 16'h0A03, 0, 16'h0000, 1, 1, 0);
        step("st_idle", 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
        check("cnt_a_3", cnt_a, 3);
        check("cnt_b_2", cnt_b, 2);

        do_reset(1);
        for (int i = 0; i < 65536; i++) begin
            @(posedge clk); #1;
            a_valid = 1'b1; a_data = 16'hE000; b_valid = 1'b0; out_ready = 1'b1;
            if (i == 65535) check("cnt_a_ffff", cnt_a, 16'hFFFF);
            exp_q.push_back({1'b0, 16'hE000});
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        check("cnt_a_wrap", cnt_a, 0);
        check("cnt_b_wrap", cnt_b, 0);
`endif

        step("drain1", 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
        step("drain2", 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
        @(posedge clk); #1;
        check("queue_empty", exp_q.size(), 0);
        check("final_out_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
